// File: rtl/fb_addr_pkg.sv
// Shared types and default geometry for the framebuffer address generator.
package fb_addr_pkg;

  localparam int unsigned DEF_X_W    = 10;
  localparam int unsigned DEF_Y_W    = 10;
  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned DEF_STRIDE = 512;
  localparam int unsigned DEF_BASE   = 0;
  localparam int unsigned DEF_H_RES  = 640;
  localparam int unsigned DEF_V_RES  = 480;

  typedef enum logic {
    MODE_POINT = 1'b0,
    MODE_RECT  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  // A coordinate outside the visible area still gets an address; this only flags it.
  function automatic logic is_oob(input int unsigned x, input int unsigned y,
                                  input int unsigned h_res, input int unsigned v_res);
    return (x >= h_res) || (y >= v_res);
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational BASE + y*STRIDE + x, wrapping modulo 2^ADDR_W.
// Only used when a command is accepted; per-beat stepping is incremental.
module fb_addr_calc
  import fb_addr_pkg::*;
#(
  parameter int unsigned X_W    = DEF_X_W,
  parameter int unsigned Y_W    = DEF_Y_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned STRIDE = DEF_STRIDE,
  parameter int unsigned BASE   = DEF_BASE
) (
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Bits above ADDR_W never reach the result, so the sum is formed at ADDR_W directly.
  always_comb begin
    addr_o = ADDR_W'(y_i) * ADDR_W'(STRIDE) + ADDR_W'(BASE) + ADDR_W'(x_i);
  end

endmodule

// File: rtl/fb_addr_gen.sv
// Framebuffer address generator: turns a point or a rectangle (raster order)
// into a stream of linear addresses with coordinate, last and out-of-bounds tags.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. A
// producer keeps valid and its payload stable until the transfer; ready may
// depend combinationally on the other side's ready (in_ready follows out_ready
// on the final beat so a new command can start with no bubble).
module fb_addr_gen
  import fb_addr_pkg::*;
#(
  parameter int unsigned X_W    = DEF_X_W,
  parameter int unsigned Y_W    = DEF_Y_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned STRIDE = DEF_STRIDE,
  parameter int unsigned BASE   = DEF_BASE,
  parameter int unsigned H_RES  = DEF_H_RES,
  parameter int unsigned V_RES  = DEF_V_RES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic              out_last,
  output logic              out_oob,
  output logic              cmd_err,
  output logic              busy,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [X_W-1:0]    out_x_q, out_x_d;
  logic [Y_W-1:0]    out_y_q, out_y_d;
  logic              out_last_q, out_last_d;
  logic              out_oob_q, out_oob_d;
  logic              cmd_err_q, cmd_err_d;
  logic [X_W-1:0]    x0_q, x0_d;
  logic [X_W-1:0]    x1_q, x1_d;
  logic [Y_W-1:0]    y1_q, y1_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  logic [ADDR_W-1:0] pt_addr, row0_addr;
  logic              out_fire, accept, degenerate;

  logic              row_end;
  logic [X_W-1:0]    step_x;
  logic [Y_W-1:0]    step_y;
  logic [ADDR_W-1:0] step_row, step_addr;

  fb_addr_calc #(
    .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .STRIDE(STRIDE), .BASE(BASE)
  ) u_calc_pt (
    .x_i   (x0),
    .y_i   (y0),
    .addr_o(pt_addr)
  );

  // Row base of the first row: the same product with x forced to zero.
  fb_addr_calc #(
    .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .STRIDE(STRIDE), .BASE(BASE)
  ) u_calc_row (
    .x_i   (X_W'(0)),
    .y_i   (y0),
    .addr_o(row0_addr)
  );

  assign out_fire   = out_valid_q && out_ready;
  assign in_ready   = (state_q == ST_IDLE) || (out_fire && out_last_q);
  assign accept     = in_valid && in_ready;
  assign degenerate = (x1 < x0) || (y1 < y0);

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_last  = out_last_q;
  assign out_oob   = out_oob_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  // Next raster position: step x within a row, or wrap to x0 and add one stride.
  always_comb begin
    row_end   = (out_x_q == x1_q);
    step_x    = out_x_q + 1'b1;
    step_y    = out_y_q;
    step_row  = row_base_q;
    step_addr = out_addr_q + 1'b1;
    if (row_end) begin
      step_x    = x0_q;
      step_y    = out_y_q + 1'b1;
      step_row  = row_base_q + STRIDE_A;
      step_addr = row_base_q + STRIDE_A + ADDR_W'(x0_q);
    end
  end

  // Next state and output register: retire/advance beats, then load a new command.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_last_d  = out_last_q;
    out_oob_d   = out_oob_q;
    cmd_err_d   = 1'b0;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    row_base_d  = row_base_q;

    if (out_fire) begin
      if (out_last_q) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end else begin
        out_x_d    = step_x;
        out_y_d    = step_y;
        out_addr_d = step_addr;
        row_base_d = step_row;
        out_last_d = (step_x == x1_q) && (step_y == y1_q);
        out_oob_d  = is_oob(32'(step_x), 32'(step_y), H_RES, V_RES);
      end
    end

    if (accept) begin
      if (mode_e'(mode) == MODE_POINT) begin
        state_d     = ST_EMIT;
        out_valid_d = 1'b1;
        out_addr_d  = pt_addr;
        out_x_d     = x0;
        out_y_d     = y0;
        out_last_d  = 1'b1;
        out_oob_d   = is_oob(32'(x0), 32'(y0), H_RES, V_RES);
      end else if (degenerate) begin
        cmd_err_d = 1'b1;
      end else begin
        state_d     = ST_SCAN;
        out_valid_d = 1'b1;
        x0_d        = x0;
        x1_d        = x1;
        y1_d        = y1;
        row_base_d  = row0_addr;
        out_addr_d  = pt_addr;
        out_x_d     = x0;
        out_y_d     = y0;
        out_last_d  = (x0 == x1) && (y0 == y1);
        out_oob_d   = is_oob(32'(x0), 32'(y0), H_RES, V_RES);
      end
    end
  end

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_last_q  <= 1'b0;
      out_oob_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      row_base_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_last_q  <= out_last_d;
      out_oob_q   <= out_oob_d;
      cmd_err_q   <= cmd_err_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      row_base_q  <= row_base_d;
    end
  end

endmodule

// File: tb/tb_fb_addr_gen.sv
// Bench for fb_addr_gen: commands are expanded into expected beats by a plain
// arithmetic model and compared beat by beat, including during stalls.
module tb_fb_addr_gen;
  import fb_addr_pkg::*;

  localparam int X_W    = 10;
  localparam int Y_W    = 10;
  localparam int ADDR_W = 19;
  localparam int STRIDE = 512;
  localparam int BASE   = 0;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int BW     = ADDR_W + X_W + Y_W + 2;

  // clock / reset / DUT signals
  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [X_W-1:0]    x0 = '0, x1 = '0;
  logic [Y_W-1:0]    y0 = '0, y1 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_addr;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic              out_last, out_oob, cmd_err, busy;
  state_e            dbg_state;

  always #5 clk = ~clk;

  fb_addr_gen #(
    .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .STRIDE(STRIDE), .BASE(BASE),
    .H_RES(H_RES), .V_RES(V_RES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_x(out_x), .out_y(out_y), .out_last(out_last), .out_oob(out_oob),
    .cmd_err(cmd_err), .busy(busy), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic           m;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
  } cmd_t;

  int chk_cnt = 0;
  int pass_cnt = 0;
  cmd_t cmd_q[$];
  logic [BW-1:0] exp_q[$];

  // reference model: one expected beat
  function automatic void push_beat(input int x, input int y, input logic last);
    longint a;
    logic [63:0] av;
    logic oob;
    a   = (longint'(BASE) + longint'(y) * STRIDE + x) % (longint'(1) << ADDR_W);
    av  = a;
    oob = (x >= H_RES) || (y >= V_RES);
    exp_q.push_back({av[ADDR_W-1:0], X_W'(x), Y_W'(y), last, oob});
  endfunction

  // reference model: whole command; returns 1 when the command is degenerate
  function automatic bit model_cmd(input cmd_t c);
    if (!c.m) begin
      push_beat(int'(c.x0), int'(c.y0), 1'b1);
      return 1'b0;
    end
    if (c.x1 < c.x0 || c.y1 < c.y0) return 1'b1;
    for (int y = int'(c.y0); y <= int'(c.y1); y++)
      for (int x = int'(c.x0); x <= int'(c.x1); x++)
        push_beat(x, y, (x == int'(c.x1)) && (y == int'(c.y1)));
    return 1'b0;
  endfunction

  // driver + scoreboard: issues cmd_q, checks every visible beat against exp_q
  // policy 0: ready held high, 1: ready pattern 1,0,0, 2: random ready
  task automatic run_stream(input int policy, input int budget, output int cycles);
    bit err_pend = 1'b0;
    bit done = 1'b0;
    int cyc = 0;
    logic [BW-1:0] obs;
    while (cyc < budget) begin
      @(negedge clk);
      case (policy)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cmd_q.size() > 0) begin
        in_valid = 1'b1;
        mode = cmd_q[0].m; x0 = cmd_q[0].x0; y0 = cmd_q[0].y0;
        x1 = cmd_q[0].x1; y1 = cmd_q[0].y1;
      end else begin
        in_valid = 1'b0;
        mode = 1'($urandom_range(0, 1));
        x0 = X_W'($urandom_range(0, 1023)); y0 = Y_W'($urandom_range(0, 1023));
        x1 = X_W'($urandom_range(0, 1023)); y1 = Y_W'($urandom_range(0, 1023));
      end
      #1;
      chk_cnt++;
      if (cmd_err !== err_pend) $display("FAIL cmd_err cyc=%0d got=%b exp=%b", cyc, cmd_err, err_pend);
      else pass_cnt++;
      err_pend = 1'b0;
      if (out_valid === 1'b1) begin
        obs = {out_addr, out_x, out_y, out_last, out_oob};
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL extra_beat got=%h exp=none", obs);
        else if (obs !== exp_q[0])
          $display("FAIL beat addr/x/y/last/oob got=%0d/%0d/%0d/%b/%b exp=%0d/%0d/%0d/%b/%b",
                   out_addr, out_x, out_y, out_last, out_oob,
                   exp_q[0][BW-1 -: ADDR_W], exp_q[0][X_W+Y_W+1 -: X_W],
                   exp_q[0][Y_W+1 -: Y_W], exp_q[0][1], exp_q[0][0]);
        else pass_cnt++;
        if (!out_ready) begin
          chk_cnt++;
          if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b exp=0", in_ready);
          else pass_cnt++;
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready === 1'b1) begin
        err_pend = model_cmd(cmd_q[0]);
        void'(cmd_q.pop_front());
      end
      cyc++;
      if (cmd_q.size() == 0 && exp_q.size() == 0 && !err_pend) begin
        done = 1'b1;
        break;
      end
    end
    cycles = cyc;
    if (!done) begin
      chk_cnt++;
      $display("FAIL stream_timeout got=%0d pending beats exp=0", exp_q.size());
      exp_q.delete();
      cmd_q.delete();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++;
    if ({out_valid, out_addr, out_x, out_y, out_last, out_oob, cmd_err, busy} !== '0)
      $display("FAIL reset_outputs got v=%b a=%0d x=%0d y=%0d l=%b o=%b e=%b b=%b exp=all 0",
               out_valid, out_addr, out_x, out_y, out_last, out_oob, cmd_err, busy);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1 || dbg_state !== ST_IDLE)
      $display("FAIL reset_release got in_ready=%b state=%0d exp=1/0", in_ready, dbg_state);
    else pass_cnt++;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    #1;
    chk_cnt++;
    if ({out_valid, busy, in_ready, cmd_err} !== 4'b0010)
      $display("FAIL %s_idle got v/busy/in_ready/err=%b%b%b%b exp=0010",
               name, out_valid, busy, in_ready, cmd_err);
    else pass_cnt++;
  endtask

  task automatic test_point();
    int cyc;
    cmd_q.push_back('{1'b0, 10'd3, 10'd2, 10'd0, 10'd0});
    run_stream(0, 20, cyc);
    chk_cnt++;
    if (cyc !== 2) $display("FAIL point_latency got=%0d exp=2", cyc);
    else pass_cnt++;
    check_idle("point");
  endtask

  task automatic test_rect();
    int cyc;
    cmd_q.push_back('{1'b1, 10'd10, 10'd1, 10'd12, 10'd2});
    run_stream(0, 50, cyc);
    chk_cnt++;
    if (cyc !== 7) $display("FAIL rect_cycles got=%0d exp=7", cyc);
    else pass_cnt++;
    check_idle("rect");
  endtask

  task automatic test_rect_stall();
    int cyc;
    cmd_q.push_back('{1'b1, 10'd10, 10'd1, 10'd12, 10'd2});
    run_stream(1, 100, cyc);
    check_idle("rect_stall");
  endtask

  task automatic test_oob();
    int cyc;
    cmd_q.push_back('{1'b0, 10'd640, 10'd0, 10'd0, 10'd0});
    cmd_q.push_back('{1'b0, 10'd1023, 10'd1023, 10'd0, 10'd0});
    run_stream(0, 20, cyc);
    chk_cnt++;
    if (cyc !== 3) $display("FAIL oob_cycles got=%0d exp=3", cyc);
    else pass_cnt++;
    check_idle("oob");
  endtask

  task automatic test_degenerate();
    int cyc;
    cmd_q.push_back('{1'b1, 10'd5, 10'd0, 10'd4, 10'd0});
    run_stream(0, 20, cyc);
    check_idle("degenerate");
  endtask

  task automatic test_back_to_back();
    int cyc;
    cmd_q.push_back('{1'b1, 10'd0, 10'd0, 10'd2, 10'd1});
    cmd_q.push_back('{1'b0, 10'd7, 10'd9, 10'd0, 10'd0});
    cmd_q.push_back('{1'b1, 10'd636, 10'd478, 10'd641, 10'd481});
    run_stream(0, 100, cyc);
    chk_cnt++;
    if (cyc !== 1 + 6 + 1 + 24) $display("FAIL b2b_cycles got=%0d exp=%0d", cyc, 1 + 6 + 1 + 24);
    else pass_cnt++;
    check_idle("b2b");
  endtask

  task automatic test_random();
    int cyc;
    cmd_t c;
    int w, h;
    for (int i = 0; i < 25; i++) begin
      c.m  = 1'($urandom_range(0, 1));
      c.x0 = X_W'($urandom_range(0, 1023));
      c.y0 = Y_W'($urandom_range(0, 1023));
      w = $urandom_range(0, 4);
      h = $urandom_range(0, 3);
      c.x1 = (int'(c.x0) + w > 1023) ? 10'd1023 : X_W'(int'(c.x0) + w);
      c.y1 = (int'(c.y0) + h > 1023) ? 10'd1023 : Y_W'(int'(c.y0) + h);
      if ($urandom_range(0, 5) == 0 && c.x0 > 0) c.x1 = c.x0 - 1'b1;
      cmd_q.push_back(c);
    end
    run_stream(2, 5000, cyc);
    check_idle("random");
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; mode = 1'b1;
    x0 = 10'd100; y0 = 10'd50; x1 = 10'd103; y1 = 10'd53;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_addr !== 19'd25703 || out_x !== 10'd103)
      $display("FAIL midscan_beat4 got v=%b addr=%0d x=%0d exp v=1 addr=25703 x=103",
               out_valid, out_addr, out_x);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({out_valid, out_addr, out_x, out_y, out_last, out_oob, cmd_err, busy} !== '0)
      $display("FAIL midscan_reset got v=%b a=%0d x=%0d y=%0d l=%b o=%b e=%b b=%b exp=all 0",
               out_valid, out_addr, out_x, out_y, out_last, out_oob, cmd_err, busy);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    cmd_q.push_back('{1'b0, 10'd0, 10'd0, 10'd0, 10'd0});
    run_stream(0, 20, cyc);
    chk_cnt++;
    if (cyc !== 2) $display("FAIL post_reset_latency got=%0d exp=2", cyc);
    else pass_cnt++;
    check_idle("post_reset");
  endtask

  initial begin
    test_reset();
    test_point();
    test_rect();
    test_rect_stall();
    test_oob();
    test_degenerate();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
